video_serializer_p: RTL and testbench
=====================================

# video_serializer_p

Parametrised pixel/attribute serializer for the ZX-compatible video path. It replaces the fixed latch and shift chain with a buffered fetch interface. Byte pairs (pixel, attribute) captured from the video RAM data bus are queued in a small FIFO and shifted out once per pixel-clock enable. Output is registered RGBI with hardware flash, border, blanking and an optional 16-colour mode. It sits between the video RAM fetch sequencer and the RGBI/SYNC output pins.

## Interface
- FIFO_DEPTH, 2: number of queued (pixel, attribute) pairs; power of two, 2..8.
- FLASH_DIV, 16: FRAME pulses per flash half-period; 1..255.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- PIX_EN  in  1  pixel-clock enable; one pixel advanced per CLK with PIX_EN=1.
- D  in  8  video RAM data bus.
- LD_PIX  in  1  capture D as pixel byte (one-CLK strobe).
- LD_ATTR  in  1  capture D as attribute byte (one-CLK strobe).
- ACTIVE  in  1  paper area flag, sampled on PIX_EN.
- BLANK  in  1  blanking flag, sampled on PIX_EN; overrides ACTIVE.
- BORDER  in  3  border colour {G,R,B}.
- FRAME  in  1  one-CLK pulse per frame; drives the flash counter.
- MODE  in  1  0 = ZX attribute mode, 1 = 16-colour mode; sampled at pair pop.
- SYNC_IN  in  1  composite sync from the timing generator.
- R, G, B, I  out  1 each  registered colour.
- SYNC  out  1  SYNC_IN delayed to align with colour.
- FIFO_OVF  out  1  sticky: push attempted while FIFO full.
- UNDERRUN  out  1  sticky: pop required while FIFO empty.

## Operation
- Pair latch:
  - LD_PIX and LD_ATTR arrive in either order.
  - The pair is pushed on the CLK where the second byte is captured.
  - Both strobes in the same CLK capture D into both bytes and push at once.
  - A repeated LD_PIX (or LD_ATTR) before its partner overwrites the held byte.
- FIFO: FIFO_DEPTH entries of 16 bits.
  - Push while full: the new pair is dropped and FIFO_OVF is set.
  - Simultaneous push and pop: occupancy is unchanged.
  - No bypass. A pop from empty with a simultaneous push reports an underrun; the pushed pair is stored.
- Serializer: 3-bit pixel counter CNT.
  - On PIX_EN with ACTIVE=1 and BLANK=0:
    - If CNT=0, pop the head pair into the working registers (PW, AW, MW=MODE).
    - Then CNT increments, wrapping 7->0.
  - Pop on empty: PW=AW=0, MW=MODE, UNDERRUN is set.
  - On PIX_EN with ACTIVE=0 or BLANK=1: CNT is forced to 0 and the rest of the current pair is discarded.
- ZX mode (MW=0):
  - Pixel bit is PW[7-CNT].
  - Flash inverts the pixel bit when AW[7]=1 and the flash phase is 1.
  - Colour is ink AW[2:0] when the bit is 1, else paper AW[5:3]; I=AW[6].
  - Colour bit mapping: bit0=B, bit1=R, bit2=G.
- 16-colour mode (MW=1):
  - The pair carries four pixels, each held for 2 PIX_EN ticks.
  - Pixel order: PW[7:4], PW[3:0], AW[7:4], AW[3:0].
  - Nibble mapping: {I,G,R,B}.
  - No flash.
- Border: ACTIVE=0, BLANK=0 gives {G,R,B}=BORDER, I=0.
- Blank: BLANK=1 gives R=G=B=I=0.
- Flash:
  - An 8-bit counter increments on FRAME.
  - When it reaches FLASH_DIV-1 it clears and the flash phase toggles.

## Timing
- Colour and SYNC register on the CLK edge where PIX_EN=1 and hold between enables. Latency is 1 CLK from the sampled PIX_EN edge.
- Pair pushed on LD edge N is poppable at edge N+1.
- Reset values:
  - R=G=B=I=0, SYNC=0.
  - FIFO empty, pair latch cleared, CNT=0.
  - Flash counter and phase 0.
  - FIFO_OVF=UNDERRUN=0.
- RST mid-line discards queued pairs; the first pop after RST with an empty FIFO sets UNDERRUN.
- A MODE change takes effect only at the next pop.
- FRAME coincident with RST: RST wins.

## Test plan
- ZX basic:
  - Stimulus: push P=0xA5, A=0x47 (ink 7, paper 0, bright); 8 PIX_EN ticks with ACTIVE=1.
  - Response: GRB = 7,0,7,0,0,7,0,7, I=1 throughout, each 1 CLK after its tick.
- Flash:
  - Stimulus: FLASH_DIV=2, A=0x81, P=0xF0; 2 FRAME pulses, then display.
  - Response: first 4 pixels are paper 0, last 4 are ink 1 (inverted).
- 16-colour:
  - Stimulus: MODE=1, P=0x9C, A=0x3F.
  - Response: {I,GRB} pairs 9,9,C,C,3,3,F,F over 8 ticks.
- Border/blank:
  - Stimulus: ACTIVE=0, BORDER=5, then BLANK=1.
  - Response: GRB=5, I=0; then all outputs 0.
  - Stimulus: ACTIVE drops at CNT=3.
  - Response: the next active pop loads a fresh pair.
- FIFO limits:
  - Stimulus: push FIFO_DEPTH+1 pairs without popping.
  - Response: FIFO_OVF=1 and the extra pair is lost.
  - Stimulus: drain, then one more pop.
  - Response: UNDERRUN=1 and the pixels are black.
- Reset:
  - Stimulus: RST mid-pair.
  - Response: next CLK has all outputs and flags 0 and CNT=0.

Source files
------------

// File: rtl/video_serializer_p.sv
// Pixel/attribute serializer: queues (pixel, attribute) byte pairs and shifts one pixel per PIX_EN as registered RGBI.
// Latency 1 CLK from PIX_EN; FIFO push-while-full drops the pair (FIFO_OVF), pop-on-empty shows black (UNDERRUN).
module video_serializer_p #(
  parameter int FIFO_DEPTH = 2,
  parameter int FLASH_DIV  = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PIX_EN,
  input  logic [7:0] D,
  input  logic       LD_PIX,
  input  logic       LD_ATTR,
  input  logic       ACTIVE,
  input  logic       BLANK,
  input  logic [2:0] BORDER,
  input  logic       FRAME,
  input  logic       MODE,
  input  logic       SYNC_IN,
  output logic       R,
  output logic       G,
  output logic       B,
  output logic       I,
  output logic       SYNC,
  output logic       FIFO_OVF,
  output logic       UNDERRUN
);

  localparam int PTR = $clog2(FIFO_DEPTH);
  localparam logic [PTR:0] DEPTH_C = (PTR+1)'(FIFO_DEPTH);

  logic [15:0]    mem [FIFO_DEPTH];
  logic [PTR-1:0] wr_ptr, rd_ptr;
  logic [PTR:0]   count;

  logic [7:0] pix_hold, attr_hold;
  logic       have_pix, have_attr;
  logic       push_req;
  logic [15:0] push_dat;

  logic [2:0] cnt;
  logic [7:0] pw, aw;
  logic       mw;
  logic [7:0] fcnt;
  logic       flash_ph;

  logic        full, empty, run, pop_req, pop, do_push;
  logic [15:0] head;
  logic [7:0]  cur_p, cur_a;
  logic        cur_m;
  logic        zx_bit;
  logic [2:0]  zx_col;
  logic [3:0]  nib, igrb_nxt;

  // The pair is complete on the strobe that supplies the missing byte.
  always_comb begin
    push_req = 1'b0;
    push_dat = {pix_hold, attr_hold};
    if (LD_PIX && LD_ATTR) begin
      push_req = 1'b1;
      push_dat = {D, D};
    end else if (LD_PIX && have_attr) begin
      push_req = 1'b1;
      push_dat = {D, attr_hold};
    end else if (LD_ATTR && have_pix) begin
      push_req = 1'b1;
      push_dat = {pix_hold, D};
    end
  end

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign run     = PIX_EN && ACTIVE && !BLANK;
  assign pop_req = run && (cnt == 3'd0);
  assign pop     = pop_req && !empty;
  assign do_push = push_req && (!full || pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    cur_p = pw;
    cur_a = aw;
    cur_m = mw;
    if (pop_req) begin
      cur_p = empty ? 8'h00 : head[15:8];
      cur_a = empty ? 8'h00 : head[7:0];
      cur_m = MODE;
    end
    zx_bit = cur_p[3'd7 - cnt] ^ (cur_a[7] & flash_ph);
    zx_col = zx_bit ? cur_a[2:0] : cur_a[5:3];
    case (cnt[2:1])
      2'd0:    nib = cur_p[7:4];
      2'd1:    nib = cur_p[3:0];
      2'd2:    nib = cur_a[7:4];
      default: nib = cur_a[3:0];
    endcase
    if (BLANK)        igrb_nxt = 4'h0;
    else if (!ACTIVE) igrb_nxt = {1'b0, BORDER};
    else if (cur_m)   igrb_nxt = nib;
    else              igrb_nxt = {cur_a[6], zx_col};
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_hold  <= 8'h00;
      attr_hold <= 8'h00;
      have_pix  <= 1'b0;
      have_attr <= 1'b0;
      cnt       <= 3'd0;
      pw        <= 8'h00;
      aw        <= 8'h00;
      mw        <= 1'b0;
      fcnt      <= 8'h00;
      flash_ph  <= 1'b0;
      {I, G, R, B} <= 4'h0;
      SYNC      <= 1'b0;
      FIFO_OVF  <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      if (push_req) begin
        have_pix  <= 1'b0;
        have_attr <= 1'b0;
      end else if (LD_PIX) begin
        pix_hold <= D;
        have_pix <= 1'b1;
      end else if (LD_ATTR) begin
        attr_hold <= D;
        have_attr <= 1'b1;
      end

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !do_push) FIFO_OVF <= 1'b1;
      if (pop_req && empty)     UNDERRUN <= 1'b1;

      if (PIX_EN) begin
        {I, G, R, B} <= igrb_nxt;
        SYNC         <= SYNC_IN;
        if (run) begin
          cnt <= cnt + 3'd1;
          if (pop_req) begin
            pw <= cur_p;
            aw <= cur_a;
            mw <= cur_m;
          end
        end else begin
          cnt <= 3'd0;
        end
      end

      if (FRAME) begin
        if (fcnt == 8'(FLASH_DIV - 1)) begin
          fcnt     <= 8'h00;
          flash_ph <= ~flash_ph;
        end else begin
          fcnt <= fcnt + 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_serializer_p.sv
// Directed bench for video_serializer_p (FIFO_DEPTH=2, FLASH_DIV=2) with hand-computed {I,G,R,B} expectations.
module tb_video_serializer_p;
  logic       CLK = 1'b0;
  logic       RST, PIX_EN, LD_PIX, LD_ATTR, ACTIVE, BLANK, FRAME, MODE, SYNC_IN;
  logic [7:0] D;
  logic [2:0] BORDER;
  logic       R, G, B, I, SYNC, FIFO_OVF, UNDERRUN;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  video_serializer_p #(.FIFO_DEPTH(2), .FLASH_DIV(2)) dut (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN), .D(D), .LD_PIX(LD_PIX), .LD_ATTR(LD_ATTR),
    .ACTIVE(ACTIVE), .BLANK(BLANK), .BORDER(BORDER), .FRAME(FRAME), .MODE(MODE),
    .SYNC_IN(SYNC_IN), .R(R), .G(G), .B(B), .I(I), .SYNC(SYNC),
    .FIFO_OVF(FIFO_OVF), .UNDERRUN(UNDERRUN)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] a);
    D = p; LD_PIX = 1'b1;
    step();
    LD_PIX = 1'b0; D = a; LD_ATTR = 1'b1;
    step();
    LD_ATTR = 1'b0;
  endtask

  task automatic pix(input logic act, input logic blk, input logic [3:0] exp, input string tag);
    PIX_EN = 1'b1; ACTIVE = act; BLANK = blk;
    step();
    PIX_EN = 1'b0;
    chk(tag, {4'h0, I, G, R, B}, {4'h0, exp});
  endtask

  logic [3:0] zx_exp [8] = '{4'hF, 4'h8, 4'hF, 4'h8, 4'h8, 4'hF, 4'h8, 4'hF};
  logic [3:0] c16_exp [8] = '{4'h9, 4'h9, 4'hC, 4'hC, 4'h3, 4'h3, 4'hF, 4'hF};

  initial begin
    RST = 1'b1; PIX_EN = 1'b0; LD_PIX = 1'b0; LD_ATTR = 1'b0; ACTIVE = 1'b0; BLANK = 1'b0;
    FRAME = 1'b0; MODE = 1'b0; SYNC_IN = 1'b0; D = 8'h00; BORDER = 3'd5;
    step(); step();
    RST = 1'b0;
    chk("reset", {1'b0, R, G, B, I, SYNC, FIFO_OVF, UNDERRUN}, 8'h00);

    // ZX attribute mode, ink 7 / paper 0 / bright
    SYNC_IN = 1'b1;
    load(8'hA5, 8'h47);
    pix(1'b1, 1'b0, zx_exp[0], "zx0");
    chk("sync_hi", {7'h0, SYNC}, 8'h01);
    step();
    chk("zx_hold", {4'h0, I, G, R, B}, 8'h0F);
    for (int i = 1; i < 8; i++) pix(1'b1, 1'b0, zx_exp[i], $sformatf("zx%0d", i));
    chk("no_underrun", {7'h0, UNDERRUN}, 8'h00);

    // border, blank, blank overriding active
    SYNC_IN = 1'b0;
    pix(1'b0, 1'b0, 4'h5, "border");
    chk("sync_lo", {7'h0, SYNC}, 8'h00);
    pix(1'b0, 1'b1, 4'h0, "blank");
    pix(1'b1, 1'b1, 4'h0, "blank_act");

    // 16-colour; MODE drop mid-pair must not take effect until next pop
    MODE = 1'b1;
    load(8'h9C, 8'h3F);
    pix(1'b1, 1'b0, c16_exp[0], "c16_0");
    MODE = 1'b0;
    for (int i = 1; i < 8; i++) pix(1'b1, 1'b0, c16_exp[i], $sformatf("c16_%0d", i));

    // two frames with FLASH_DIV=2 -> flash phase 1
    for (int f = 0; f < 2; f++) begin
      FRAME = 1'b1; step(); FRAME = 1'b0; step();
    end
    load(8'hF0, 8'h81);
    for (int i = 0; i < 8; i++) pix(1'b1, 1'b0, (i < 4) ? 4'h0 : 4'h1, $sformatf("flash%0d", i));

    // ACTIVE drop at CNT=3 discards the rest of the pair
    load(8'hFF, 8'h07);
    load(8'h00, 8'h10);
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b0, 4'h7, $sformatf("drop_a%0d", i));
    pix(1'b0, 1'b0, 4'h5, "drop_border");
    pix(1'b1, 1'b0, 4'h2, "drop_fresh");
    pix(1'b0, 1'b0, 4'h5, "drop_border2");

    // FIFO overflow then drain and underrun
    load(8'hFF, 8'h01);
    load(8'hFF, 8'h02);
    chk("ovf_before", {7'h0, FIFO_OVF}, 8'h00);
    load(8'hFF, 8'h03);
    chk("ovf_after", {7'h0, FIFO_OVF}, 8'h01);
    for (int i = 0; i < 16; i++) pix(1'b1, 1'b0, (i < 8) ? 4'h1 : 4'h2, $sformatf("drain%0d", i));
    chk("underrun_before", {7'h0, UNDERRUN}, 8'h00);
    pix(1'b1, 1'b0, 4'h0, "underrun_black");
    chk("underrun_after", {7'h0, UNDERRUN}, 8'h01);
    pix(1'b0, 1'b0, 4'h5, "pre_rst_border");

    // reset with a pixel byte held in the pair latch
    D = 8'hFF; LD_PIX = 1'b1; step(); LD_PIX = 1'b0;
    RST = 1'b1; step(); RST = 1'b0;
    chk("rst_mid", {1'b0, R, G, B, I, SYNC, FIFO_OVF, UNDERRUN}, 8'h00);
    D = 8'h02; LD_ATTR = 1'b1; step(); LD_ATTR = 1'b0;
    pix(1'b1, 1'b0, 4'h0, "rst_empty_pop");
    chk("rst_underrun", {7'h0, UNDERRUN}, 8'h01);
    pix(1'b0, 1'b0, 4'h5, "rst_border");
    D = 8'hFF; LD_PIX = 1'b1; step(); LD_PIX = 1'b0;
    pix(1'b1, 1'b0, 4'h2, "rst_pair");
    pix(1'b0, 1'b0, 4'h5, "rst_border2");
    load(8'hF0, 8'h81);
    pix(1'b1, 1'b0, 4'h1, "rst_flash_phase");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
